// File: rtl/multdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_ctrl
// Purpose  : Execute-stage sequencer for the multi-cycle multiply/divide unit.
//            Decodes mul/div, pulses the unit start, stalls the pipe until the
//            unit is ready (or the watchdog fires), then releases the insn
//            with the captured result for one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module multdiv_ctrl #(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] insn_x,
  input  logic        valid_x,
  input  logic        flush,
  input  logic        md_resultRDY,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        stall,
  output logic        busy,
  output logic [31:0] result,
  output logic [4:0]  result_rd,
  output logic        result_valid,
  output logic        exception,
  output logic        timeout
);

  localparam logic [4:0]       C_ALU_MUL  = 5'b00110;
  localparam logic [4:0]       C_ALU_DIV  = 5'b00111;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_op_div;
  logic [4:0]       r_rd_pend;
  logic [31:0]      r_result;
  logic [4:0]       r_rd;
  logic             r_exc;
  logic             r_tmo;

  logic             w_is_md;
  logic             w_go;
  logic             w_cnt_last;
  logic             w_unused;

  // Only the opcode, rd and ALU-op fields matter to this block.
  assign w_unused   = ^{insn_x[21:7], insn_x[1:0]};

  assign w_is_md    = (insn_x[31:27] == 5'b00000) &&
                      ((insn_x[6:2] == C_ALU_MUL) || (insn_x[6:2] == C_ALU_DIV));
  assign w_go       = valid_x & w_is_md & ~flush;
  assign w_cnt_last = (r_cnt == C_CNT_LAST);

  assign result     = r_result;
  assign result_rd  = r_rd;
  assign exception  = r_exc;
  assign timeout    = r_tmo;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and state-decoded control outputs; stall is combinational in
  // IDLE so the md insn is frozen on its very first X cycle.
  always_comb begin
    w_next       = r_state;
    stall        = 1'b0;
    busy         = 1'b0;
    ctrl_MULT    = 1'b0;
    ctrl_DIV     = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          stall  = 1'b1;
          w_next = S_START;
        end
      end
      S_START: begin
        stall     = 1'b1;
        busy      = 1'b1;
        ctrl_MULT = ~r_op_div;
        ctrl_DIV  = r_op_div;
        w_next    = flush ? S_IDLE : S_BUSY;
      end
      S_BUSY: begin
        stall = 1'b1;
        busy  = 1'b1;
        if (flush) begin
          w_next = S_IDLE;
        end else if (md_resultRDY || w_cnt_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        busy         = 1'b1;
        result_valid = 1'b1;
        w_next       = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Op/rd latch at issue, watchdog counter, and result capture on completion.
  // A flushed op leaves the visible result registers untouched.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt     <= '0;
      r_op_div  <= 1'b0;
      r_rd_pend <= '0;
      r_result  <= '0;
      r_rd      <= '0;
      r_exc     <= 1'b0;
      r_tmo     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_op_div  <= (insn_x[6:2] == C_ALU_DIV);
            r_rd_pend <= insn_x[26:22];
          end
        end
        S_START: begin
          r_cnt <= '0;
        end
        S_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (!flush) begin
            if (md_resultRDY) begin
              r_result <= md_result;
              r_exc    <= md_exception;
              r_tmo    <= 1'b0;
              r_rd     <= r_rd_pend;
            end else if (w_cnt_last) begin
              r_result <= '0;
              r_exc    <= 1'b1;
              r_tmo    <= 1'b1;
              r_rd     <= r_rd_pend;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multdiv_ctrl
// Purpose  : Directed, table-driven self-checking bench for multdiv_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multdiv_ctrl;

  localparam int MAXC = 8;

  // Expected control word: {stall, ctrl_MULT, ctrl_DIV, busy, result_valid}
  localparam logic [4:0] C_IDLE = 5'b00000;
  localparam logic [4:0] C_GO   = 5'b10000;
  localparam logic [4:0] C_SM   = 5'b11010;
  localparam logic [4:0] C_SD   = 5'b10110;
  localparam logic [4:0] C_BUSY = 5'b10010;
  localparam logic [4:0] C_DONE = 5'b00011;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] insn_x;
  logic        valid_x;
  logic        flush;
  logic        md_resultRDY;
  logic        md_exception;
  logic [31:0] md_result;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        stall;
  logic        busy;
  logic [31:0] result;
  logic [4:0]  result_rd;
  logic        result_valid;
  logic        exception;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  multdiv_ctrl #(.MAX_CYCLES(MAXC), .CNT_W(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .insn_x       (insn_x),
    .valid_x      (valid_x),
    .flush        (flush),
    .md_resultRDY (md_resultRDY),
    .md_exception (md_exception),
    .md_result    (md_result),
    .ctrl_MULT    (ctrl_MULT),
    .ctrl_DIV     (ctrl_DIV),
    .stall        (stall),
    .busy         (busy),
    .result       (result),
    .result_rd    (result_rd),
    .result_valid (result_valid),
    .exception    (exception),
    .timeout      (timeout)
  );

  typedef struct {
    logic [31:0] insn;
    logic        valid;
    logic        flsh;
    logic        rdy;
    logic        exc;
    logic [31:0] mdres;
    logic [4:0]  ectl;
    logic [31:0] eres;
    logic [4:0]  erd;
    logic        eexc;
    logic        etmo;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] alu);
    return {op, rd, 5'd1, 5'd2, 5'd0, alu, 2'b00};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] insn, input logic valid, input logic flsh,
                       input logic rdy, input logic exc, input logic [31:0] mdres);
    insn_x       = insn;
    valid_x      = valid;
    flush        = flsh;
    md_resultRDY = rdy;
    md_exception = exc;
    md_result    = mdres;
  endtask

  task automatic addv(input logic [31:0] insn, input logic valid, input logic flsh,
                      input logic rdy, input logic exc, input logic [31:0] mdres,
                      input logic [4:0] ectl, input logic [31:0] eres,
                      input logic [4:0] erd, input logic eexc, input logic etmo);
    vec_t v;
    v.insn = insn; v.valid = valid; v.flsh = flsh; v.rdy = rdy; v.exc = exc;
    v.mdres = mdres; v.ectl = ectl; v.eres = eres; v.erd = erd;
    v.eexc = eexc; v.etmo = etmo;
    vecs.push_back(v);
  endtask

  // Sample on the falling edge, then advance past the next rising edge.
  task automatic step(input string tag, input logic [4:0] ectl, input logic [31:0] eres,
                      input logic [4:0] erd, input logic eexc, input logic etmo);
    @(negedge clock);
    chk({tag, " ctl"}, {27'd0, stall, ctrl_MULT, ctrl_DIV, busy, result_valid}, {27'd0, ectl});
    chk({tag, " result"}, result, eres);
    chk({tag, " rd/exc/tmo"}, {25'd0, result_rd, exception, timeout}, {25'd0, erd, eexc, etmo});
    @(posedge clock);
    #1;
  endtask

  logic [31:0] MUL1, MUL2, MUL3, MUL4, MUL7, MUL9, DIV5, DIV6, DIV10, ADD8, BADOP, NOP;

  initial begin
    MUL1  = mk(5'd0, 5'd1,  5'b00110);
    MUL2  = mk(5'd0, 5'd2,  5'b00110);
    MUL3  = mk(5'd0, 5'd3,  5'b00110);
    MUL4  = mk(5'd0, 5'd4,  5'b00110);
    MUL7  = mk(5'd0, 5'd7,  5'b00110);
    MUL9  = mk(5'd0, 5'd9,  5'b00110);
    DIV5  = mk(5'd0, 5'd5,  5'b00111);
    DIV6  = mk(5'd0, 5'd6,  5'b00111);
    DIV10 = mk(5'd0, 5'd10, 5'b00111);
    ADD8  = mk(5'd0, 5'd8,  5'b00000);
    BADOP = mk(5'd1, 5'd8,  5'b00110);
    NOP   = 32'd0;

    // mul r3: RDY on the 4th BUSY cycle, result 0x2A
    addv(MUL3,1,0,0,0,0,     C_GO,  0,0,0,0);
    addv(MUL3,1,0,0,0,0,     C_SM,  0,0,0,0);
    addv(MUL3,1,0,0,0,0,     C_BUSY,0,0,0,0);
    addv(MUL3,1,0,0,0,0,     C_BUSY,0,0,0,0);
    addv(MUL3,1,0,0,0,0,     C_BUSY,0,0,0,0);
    addv(MUL3,1,0,1,0,32'h2A,C_BUSY,0,0,0,0);
    addv(NOP, 0,0,0,0,0,     C_DONE,32'h2A,3,0,0);
    addv(NOP, 0,0,0,0,0,     C_IDLE,32'h2A,3,0,0);
    // div r5 by zero; RDY in START and IDLE must be ignored
    addv(DIV5,1,0,0,0,0,     C_GO,  32'h2A,3,0,0);
    addv(DIV5,1,0,1,0,32'h99,C_SD,  32'h2A,3,0,0);
    addv(DIV5,1,0,0,0,0,     C_BUSY,32'h2A,3,0,0);
    addv(DIV5,1,0,1,1,0,     C_BUSY,32'h2A,3,0,0);
    addv(NOP, 0,0,0,0,0,     C_DONE,0,5,1,0);
    addv(NOP, 0,0,1,0,32'h77,C_IDLE,0,5,1,0);
    addv(NOP, 0,0,0,0,0,     C_IDLE,0,5,1,0);
    // flush in BUSY (cycle 3), late RDY ignored, result unchanged
    addv(MUL7,1,0,0,0,0,     C_GO,  0,5,1,0);
    addv(MUL7,1,0,0,0,0,     C_SM,  0,5,1,0);
    addv(MUL7,1,0,0,0,0,     C_BUSY,0,5,1,0);
    addv(MUL7,1,1,0,0,0,     C_BUSY,0,5,1,0);
    addv(NOP, 0,0,0,0,0,     C_IDLE,0,5,1,0);
    addv(NOP, 0,0,1,0,32'h5A,C_IDLE,0,5,1,0);
    addv(NOP, 0,0,0,0,0,     C_IDLE,0,5,1,0);
    // flush in START: pulse still issued, then IDLE
    addv(MUL9,1,0,0,0,0,     C_GO,  0,5,1,0);
    addv(MUL9,1,1,0,0,0,     C_SM,  0,5,1,0);
    addv(NOP, 0,0,1,0,32'h66,C_IDLE,0,5,1,0);
    addv(NOP, 0,0,0,0,0,     C_IDLE,0,5,1,0);
    // non-md, bubble, flushed md, wrong opcode: never start
    addv(ADD8, 1,0,0,0,0,    C_IDLE,0,5,1,0);
    addv(ADD8, 1,0,0,0,0,    C_IDLE,0,5,1,0);
    addv(MUL3, 0,0,0,0,0,    C_IDLE,0,5,1,0);
    addv(MUL3, 1,1,0,0,0,    C_IDLE,0,5,1,0);
    addv(BADOP,1,0,0,0,0,    C_IDLE,0,5,1,0);
    addv(NOP,  0,0,0,0,0,    C_IDLE,0,5,1,0);
    // back-to-back mul r4 then div r6, RDY after 2 BUSY cycles each
    addv(MUL4,1,0,0,0,0,     C_GO,  0,5,1,0);
    addv(MUL4,1,0,0,0,0,     C_SM,  0,5,1,0);
    addv(MUL4,1,0,0,0,0,     C_BUSY,0,5,1,0);
    addv(MUL4,1,0,1,0,32'h11,C_BUSY,0,5,1,0);
    addv(MUL4,1,0,0,0,0,     C_DONE,32'h11,4,0,0);
    addv(DIV6,1,0,0,0,0,     C_GO,  32'h11,4,0,0);
    addv(DIV6,1,0,0,0,0,     C_SD,  32'h11,4,0,0);
    addv(DIV6,1,0,0,0,0,     C_BUSY,32'h11,4,0,0);
    addv(DIV6,1,0,1,0,32'h22,C_BUSY,32'h11,4,0,0);
    addv(NOP, 0,0,0,0,0,     C_DONE,32'h22,6,0,0);
    addv(NOP, 0,0,0,0,0,     C_IDLE,32'h22,6,0,0);

    // Reset state
    reset = 1'b1;
    drive(NOP, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    step("reset", C_IDLE, 0, 0, 0, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].insn, vecs[i].valid, vecs[i].flsh, vecs[i].rdy, vecs[i].exc, vecs[i].mdres);
      step($sformatf("vec%0d", i), vecs[i].ectl, vecs[i].eres, vecs[i].erd,
           vecs[i].eexc, vecs[i].etmo);
    end

    // Watchdog: RDY never arrives, DONE after MAXC BUSY cycles
    drive(MUL2, 1, 0, 0, 0, 0);
    step("wd go",    C_GO, 32'h22, 6, 0, 0);
    step("wd start", C_SM, 32'h22, 6, 0, 0);
    for (int i = 0; i < MAXC; i++) step($sformatf("wd busy%0d", i), C_BUSY, 32'h22, 6, 0, 0);
    drive(NOP, 0, 0, 0, 0, 0);
    step("wd done", C_DONE, 0, 2, 1, 1);
    step("wd idle", C_IDLE, 0, 2, 1, 1);

    // RDY on the last watchdog cycle is a normal completion
    drive(DIV10, 1, 0, 0, 0, 0);
    step("rt go",    C_GO, 0, 2, 1, 1);
    step("rt start", C_SD, 0, 2, 1, 1);
    for (int i = 0; i < MAXC - 1; i++) step($sformatf("rt busy%0d", i), C_BUSY, 0, 2, 1, 1);
    drive(DIV10, 1, 0, 1, 0, 32'h55);
    step("rt last", C_BUSY, 0, 2, 1, 1);
    drive(NOP, 0, 0, 0, 0, 0);
    step("rt done", C_DONE, 32'h55, 10, 0, 0);

    // Reset during BUSY clears everything; a following mul runs normally
    drive(MUL1, 1, 0, 0, 0, 0);
    step("rs go",    C_GO,   32'h55, 10, 0, 0);
    step("rs start", C_SM,   32'h55, 10, 0, 0);
    step("rs busy",  C_BUSY, 32'h55, 10, 0, 0);
    reset = 1'b1;
    step("rs assert", C_BUSY, 32'h55, 10, 0, 0);
    reset = 1'b0;
    drive(NOP, 0, 0, 0, 0, 0);
    step("rs cleared", C_IDLE, 0, 0, 0, 0);
    drive(MUL3, 1, 0, 0, 0, 0);
    step("rs2 go",    C_GO,   0, 0, 0, 0);
    step("rs2 start", C_SM,   0, 0, 0, 0);
    drive(MUL3, 1, 0, 1, 0, 32'h2A);
    step("rs2 busy",  C_BUSY, 0, 0, 0, 0);
    drive(NOP, 0, 0, 0, 0, 0);
    step("rs2 done",  C_DONE, 32'h2A, 3, 0, 0);
    step("rs2 idle",  C_IDLE, 32'h2A, 3, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
